// File: rtl/fetch_aligner.sv
// fetch_aligner -- fetch-stage realigner between instruction memory and the
// RV32C decompressor.
//
// Issues word-aligned fetches (one outstanding at most), buffers returned
// words as halfwords and presents one instruction per out_valid/out_ready
// handshake together with its PC and a compressed flag. A redirect flushes
// the buffer and restarts fetch at any halfword-aligned target. A response
// that belongs to a flushed request is discarded.
//
// Configuration macro: FETCH_ALIGNER_RVC_EN
//   defined   : 16-bit (compressed) instructions are recognised.
//   undefined : everything is a 32-bit instruction, out_compressed is 0 and
//               redirect targets are forced to word alignment.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   redirect_valid, redirect_pc      flush and restart at redirect_pc
//   fetch_req_valid/ready/addr       word fetch request to memory
//   fetch_rsp_valid/data             in-order fetch response
//   out_valid/ready                  instruction handshake to decompressor
//   out_instr, out_pc, out_compressed
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_req_valid,
  output logic [31:0] fetch_req_addr,
  input  logic        fetch_req_ready,
  input  logic        fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed,
  input  logic        out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0][15:0] r_buf, w_buf_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_out_pc;
  logic             r_skip_low;

  logic [15:0] w_h0, w_h1;
  logic        w_h0_c;
  logic        w_pop;
  logic [2:0]  w_pop_n;
  logic        w_take;
  logic [2:0]  w_push_n;
  logic [2:0]  w_base;
  logic        w_req_fire;
  logic [31:0] w_redir_out_pc;
  logic        w_redir_skip;
  logic        w_unused_ok;

  assign w_h0 = r_buf[0];
  assign w_h1 = r_buf[1];

`ifdef FETCH_ALIGNER_RVC_EN
  assign w_h0_c         = (w_h0[1:0] != 2'b11);
  assign w_redir_out_pc = redirect_pc & 32'hFFFF_FFFE;
  assign w_redir_skip   = redirect_pc[1];
`else
  assign w_h0_c         = 1'b0;
  assign w_redir_out_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_redir_skip   = 1'b0;
`endif

  // redirect_pc[0] is never meaningful; [1] is unused without RVC.
  assign w_unused_ok = ^redirect_pc[1:0];

  // ---------------------------------------------------------------- output
  assign out_valid      = w_h0_c ? (r_cnt >= 3'd1) : (r_cnt >= 3'd2);
  // Gate on a non-empty buffer so an empty (all-zero) head does not read as
  // a compressed instruction.
  assign out_compressed = w_h0_c && (r_cnt != 3'd0);
  assign out_instr      = w_h0_c ? {16'h0000, w_h0} : {w_h1, w_h0};
  assign out_pc         = r_out_pc;

  // ----------------------------------------------------------------- fetch
  // count<=2 leaves room for a full word even if nothing is popped before
  // the response lands, so push+pop can never overflow the 4-entry buffer.
  assign fetch_req_valid = (r_state == S_IDLE) && (r_cnt <= 3'd2) &&
                           !redirect_valid && !rst;
  assign fetch_req_addr  = r_fetch_pc;
  assign w_req_fire      = fetch_req_valid && fetch_req_ready;

  // A pop coinciding with a redirect is dropped along with the whole buffer.
  assign w_pop    = out_valid && out_ready && !redirect_valid;
  assign w_pop_n  = w_h0_c ? 3'd1 : 3'd2;
  assign w_take   = (r_state == S_WAIT) && fetch_rsp_valid && !redirect_valid;
  assign w_push_n = r_skip_low ? 3'd1 : 3'd2;

  // --------------------------------------------------------- buffer update
  always_comb begin
    w_buf_nxt = r_buf;
    w_base    = r_cnt;
    w_cnt_nxt = r_cnt;
    if (w_pop) begin
      w_base = r_cnt - w_pop_n;
      if (w_pop_n == 3'd1) w_buf_nxt = {16'h0000, r_buf[3:1]};
      else                 w_buf_nxt = {32'h0000_0000, r_buf[3:2]};
    end
    if (w_take) begin
      // Push lands just after whatever survives this cycle's pop.
      for (int i = 0; i < 4; i++) begin
        if (r_skip_low) begin
          if (3'(i) == w_base) w_buf_nxt[i] = fetch_rsp_data[31:16];
        end else begin
          if (3'(i) == w_base)         w_buf_nxt[i] = fetch_rsp_data[15:0];
          if (3'(i) == w_base + 3'd1)  w_buf_nxt[i] = fetch_rsp_data[31:16];
        end
      end
      w_cnt_nxt = w_base + w_push_n;
    end else begin
      w_cnt_nxt = w_base;
    end
    if (redirect_valid) begin
      w_buf_nxt = '0;
      w_cnt_nxt = 3'd0;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire) w_state_nxt = S_WAIT;
      // A response in the redirect cycle closes the request (data dropped),
      // so only a still-pending request becomes stale.
      S_WAIT: begin
        if (fetch_rsp_valid)     w_state_nxt = S_IDLE;
        else if (redirect_valid) w_state_nxt = S_DROP;
      end
      S_DROP: if (fetch_rsp_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_cnt      <= 3'd0;
      r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      r_out_pc   <= RESET_PC;
      r_skip_low <= 1'b0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        r_out_pc   <= w_redir_out_pc;
        r_skip_low <= w_redir_skip;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_pop)      r_out_pc   <= r_out_pc + {28'h0, w_pop_n, 1'b0};
        if (w_take)     r_skip_low <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Testbench for fetch_aligner: directed scenarios plus randomized traffic,
// checked against a reference that walks the instruction stream directly
// from a memory image (PC -> halfword -> length) instead of tracking buffers.
module tb_fetch_aligner;

`ifdef FETCH_ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_addr;
  logic        fetch_req_ready;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_ready;

  fetch_aligner #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_compressed(out_compressed), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } out_t;
  out_t        olog[$];
  logic [31:0] falog[$];

  // stimulus knobs
  bit          run = 1'b0;
  int          k_rdy = 100, k_ordy = 100, k_lat = 1;
  bit          k_hold = 1'b0, k_redir_req = 1'b0, k_redir_wait = 1'b0;
  bit          k_rand_redir = 1'b0;
  logic [31:0] k_redir_pc = 32'h0;

  // memory + reference state
  bit          pend_v = 1'b0;
  logic [31:0] pend_addr;
  int          pend_due, cyc = 0, n_hs = 0;
  logic [31:0] m_pc, m_fetch;

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic void exp_out(input logic [31:0] pc, output logic [31:0] ins,
                                  output logic c, output logic [31:0] len);
    logic [15:0] h0, h1;
    h0  = hw(pc);
    h1  = hw(pc + 32'd2);
    c   = RVC && (h0[1:0] != 2'b11);
    ins = c ? {16'h0000, h0} : {h1, h0};
    len = c ? 32'd2 : 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input int idx, input logic [31:0] ins, input logic [31:0] pc,
                         input logic c);
    n_tests++;
    if (idx >= olog.size()) begin
      n_fail++;
      $display("FAIL log[%0d]: got no instruction expected instr=%h pc=%h", idx, ins, pc);
    end else if (olog[idx].instr !== ins || olog[idx].pc !== pc || olog[idx].c !== c) begin
      n_fail++;
      $display("FAIL log[%0d]: got instr=%h pc=%h c=%0d expected instr=%h pc=%h c=%0d",
               idx, olog[idx].instr, olog[idx].pc, olog[idx].c, ins, pc, c);
    end
  endtask

  // Drive one cycle of memory/consumer stimulus, then check DUT outputs
  // against the reference and advance it for the coming clock edge.
  always @(negedge clk) begin
    logic [31:0] ei, elen;
    logic        ec;
    out_t        o;
    if (run) begin
      fetch_rsp_valid = 1'b0;
      if (pend_v && cyc >= pend_due) begin
        fetch_rsp_valid = 1'b1;
        fetch_rsp_data  = mem[pend_addr[9:2]];
        pend_v          = 1'b0;
      end
      fetch_req_ready = ($urandom_range(99) < k_rdy);
      out_ready       = !k_hold && ($urandom_range(99) < k_ordy);
      redirect_valid  = 1'b0;
      if (k_redir_req && (!k_redir_wait || pend_v)) begin
        redirect_valid = 1'b1;
        redirect_pc    = k_redir_pc;
        k_redir_req    = 1'b0;
      end else if (k_rand_redir && $urandom_range(79) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom_range(1) == 1 ? $urandom() : 32'($urandom_range(1023));
      end
      #1;
      if (redirect_valid) chk("no_fetch_in_redirect", {31'h0, fetch_req_valid}, 32'h0);
      if (fetch_req_valid) begin
        chk("fetch_addr", fetch_req_addr, m_fetch);
        chk("one_outstanding", {31'h0, pend_v}, 32'h0);
      end
      if (out_valid) begin
        exp_out(m_pc, ei, ec, elen);
        n_tests++;
        if (out_instr !== ei || out_pc !== m_pc || out_compressed !== ec) begin
          n_fail++;
          $display("FAIL out: got instr=%h pc=%h c=%0d expected instr=%h pc=%h c=%0d",
                   out_instr, out_pc, out_compressed, ei, m_pc, ec);
        end
        if (out_ready && !redirect_valid) begin
          o.instr = out_instr; o.pc = out_pc; o.c = out_compressed;
          olog.push_back(o);
          m_pc = m_pc + elen;
          n_hs++;
        end
      end
      if (redirect_valid) begin
        m_pc    = RVC ? (redirect_pc & 32'hFFFF_FFFE) : (redirect_pc & 32'hFFFF_FFFC);
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
        olog.delete();
        falog.delete();
      end
      if (fetch_req_valid && fetch_req_ready) begin
        falog.push_back(fetch_req_addr);
        pend_v    = 1'b1;
        pend_addr = fetch_req_addr;
        pend_due  = cyc + (k_lat == 0 ? int'($urandom_range(3, 1)) : k_lat);
        m_fetch   = m_fetch + 32'd4;
      end
      cyc++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    run = 1'b0; rst = 1'b1; pend_v = 1'b0; k_redir_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_req_ready = 1'b0;
    fetch_rsp_valid = 1'b0; fetch_rsp_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_fetch_req_valid", {31'h0, fetch_req_valid}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, RST_PC);
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    m_pc = RST_PC; m_fetch = RST_PC & 32'hFFFF_FFFC;
    olog.delete(); falog.delete();
    rst = 1'b0; run = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc, input int cycles);
    k_redir_pc = pc; k_redir_req = 1'b1;
    for (int i = 0; i < 60 && k_redir_req; i++) @(posedge clk);
    chk("redirect_issued", {31'h0, k_redir_req}, 32'h0);
    k_redir_req = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[8'h40] = 32'h00A0_0093;   // 0x100: addi
    mem[8'h00] = 32'h4501_4585;   // 0x000
    mem[8'h02] = 32'h0093_4585;   // 0x008
    mem[8'h03] = 32'h0000_00A0;   // 0x00C
    mem[8'h80] = 32'h4501_1234;   // 0x200

    do_reset();
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_compressed", {31'h0, out_compressed}, 32'h0);
    release_reset();
    repeat (8) @(posedge clk);
    chk("first_fetch_addr", falog.size() > 0 ? falog[0] : 32'hDEAD_BEEF, 32'h100);
    chk_log(0, 32'h00A0_0093, 32'h100, 1'b0);

    // two compressed halfwords in one word
    redirect_to(32'h0, 12);
`ifdef FETCH_ALIGNER_RVC_EN
    chk_log(0, 32'h0000_4585, 32'h0, 1'b1);
    chk_log(1, 32'h0000_4501, 32'h2, 1'b1);
`else
    chk_log(0, 32'h4501_4585, 32'h0, 1'b0);
    chk_log(1, 32'h0000_0013, 32'h4, 1'b0);
`endif

    // instruction spanning two words, slow memory
    k_lat = 3;
    redirect_to(32'h8, 16);
`ifdef FETCH_ALIGNER_RVC_EN
    chk_log(0, 32'h0000_4585, 32'h8, 1'b1);
    chk_log(1, 32'h00A0_0093, 32'hA, 1'b0);
`else
    chk_log(0, 32'h0093_4585, 32'h8, 1'b0);
    chk_log(1, 32'h0000_00A0, 32'hC, 1'b0);
`endif

    // redirect while a fetch is outstanding -> stale response dropped
    k_redir_wait = 1'b1;
    redirect_to(32'h202, 16);
    k_redir_wait = 1'b0;
    chk("redir_fetch_addr", falog.size() > 0 ? falog[0] : 32'hDEAD_BEEF, 32'h200);
`ifdef FETCH_ALIGNER_RVC_EN
    chk_log(0, 32'h0000_4501, 32'h202, 1'b1);
`else
    chk_log(0, 32'h4501_1234, 32'h200, 1'b0);
`endif

    // consumer stalled: buffer fills and fetch stops
    k_lat = 1; k_hold = 1'b1;
    redirect_to(32'h300, 25);
    @(negedge clk); #2;
    chk("full_no_fetch", {31'h0, fetch_req_valid}, 32'h0);
    chk("full_out_valid", {31'h0, out_valid}, 32'h1);
    chk("full_fetch_count", falog.size(), 32'd2);
    k_hold = 1'b0;
    repeat (12) @(posedge clk);
    chk("resume_after_stall", {31'h0, olog.size() > 0}, 32'h1);

    // randomized traffic over a random image
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    release_reset();
    k_rdy = 70; k_ordy = 75; k_lat = 0; k_rand_redir = 1'b1; n_hs = 0;
    repeat (3000) @(posedge clk);
    do_reset();   // mid-traffic reset, memory side reset as well
    release_reset();
    repeat (1500) @(posedge clk);
    run = 1'b0;
    chk("liveness", {31'h0, n_hs > 500}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Sits between instruction memory and the RV32C decompressor in the fetch stage.
- Issues word-aligned fetches and buffers returned words as halfwords.
- Re-aligns the mixed 16/32-bit instruction stream and presents one instruction per handshake, with its PC and a compressed flag, to the decompressor input.
- Handles redirects (branch/jump) to any halfword-aligned target and discards stale in-flight fetch data.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new PC; bit 0 ignored
- fetch_req_valid  out  1  fetch request
- fetch_req_addr  out  32  word address; bits [1:0] always 0
- fetch_req_ready  in  1  memory accepts request
- fetch_rsp_valid  in  1  response data valid; in order
- fetch_rsp_data  in  32  fetched word, little-endian halfwords
- out_valid  out  1  instruction available to decompressor
- out_instr  out  32  {h1,h0} for 32-bit; {16'h0,h0} for compressed
- out_pc  out  32  PC of out_instr
- out_compressed  out  1  h0[1:0] != 2'b11
- out_ready  in  1  decompressor/decode accepts

Interface: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset values: state IDLE; buffer count 0; fetch_pc = RESET_PC & ~3; out_pc = RESET_PC; out_valid 0; fetch_req_valid 0; out_instr 0; out_compressed 0.
- Buffer: 4 halfword entries (h0 is the head) plus a 3-bit count 0..4. Push appends 2 halfwords (1 if skip_low is set). Pop removes 1 or 2 halfwords.
- FSM:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, data valid.
  - DROP: one request outstanding, data stale.
- Fetch issue: fetch_req_valid = (state==IDLE) && (count<=2) && !redirect_valid && !rst.
  - On fetch_req_valid & fetch_req_ready: state -> WAIT; fetch_pc += 4.
- WAIT + fetch_rsp_valid: push the word; state -> IDLE.
  - If skip_low is set, drop the low halfword, push only [31:16], then clear skip_low.
- DROP + fetch_rsp_valid: discard the word; state -> IDLE.
- Output:
  - out_valid = count>=1 and h0 is compressed, or count>=2 and h0 is 32-bit.
  - out_instr, out_pc and out_compressed are combinational from the buffer head and the PC register.
- Pop on out_valid & out_ready:
  - Remove 1 halfword if compressed, 2 if 32-bit.
  - out_pc += 2 or += 4 respectively.
- Push and pop in the same cycle are both applied; the net count must stay <= 4. The issue rule guarantees this.
- Redirect (highest priority, same cycle):
  - Clear the buffer (count 0).
  - out_pc = redirect_pc & ~1; fetch_pc = redirect_pc & ~3; skip_low = redirect_pc[1].
  - WAIT -> DROP; IDLE stays IDLE; DROP stays DROP.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the same cycle is ignored; the handshake still completes downstream, and the consumer must drop it.
- Next fetch after a redirect issues no earlier than the cycle following the redirect.
- A 32-bit instruction spanning two words is held until the second word arrives; out_valid stays low meanwhile.
- PC arithmetic wraps modulo 2^32.
- rst asserted mid-fetch: the FSM returns to IDLE. The memory side must also reset; the block does not track the orphaned response.

Optional Feature:
- Macro FETCH_ALIGNER_RVC_EN.
- Defined: behaviour as above.
- Undefined:
  - Every instruction is treated as 32-bit and out_compressed is tied 0.
  - Pop is always 2 halfwords; redirect_pc[1:0] are ignored; skip_low is never set.
  - An instruction whose h0[1:0] != 2'b11 is passed unchanged as 32-bit.

Test Plan:
- Reset, RESET_PC=0x100; memory returns 0x00A00093 (addi) at 0x100 with zero-wait ready and 1-cycle response -> first fetch_req_addr=0x100; out_valid with out_instr=0x00A00093, out_pc=0x100, out_compressed=0.
- Word 0x4501_4585 at 0x0 (two compressed) -> out_instr=0x00004585 @pc 0x0, then 0x00004501 @pc 0x2, each with out_compressed=1.
- Word0=0x0093_4585, word1=0xXXXX_00A0 -> compressed 0x4585 @0x0, then spanning instruction out_instr=0x00A00093 @0x2; out_valid stays low until word1 is pushed.
- Redirect to 0x202 while in WAIT -> in-flight response discarded (DROP -> IDLE); next fetch_req_addr=0x200; first out_pc=0x202 using the high halfword only.
- out_ready held 0 with buffer full (count 4) -> fetch_req_valid stays 0, no overflow; releasing out_ready resumes fetch.
- Build without FETCH_ALIGNER_RVC_EN, word 0x4501_4585 -> single output 0x45014585 @pc 0x0, out_compressed=0, out_pc then 0x4.
